// File: rtl/memory_module_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_module_pkg
//  Description : Control-word layout shared with the control unit, plus the
//                state encoding of the memory stage (clear / run / load).
//  Revision    : 1.0 - initial release
// ============================================================================
package memory_module_pkg;

  // Width of the registered control word issued by the control unit
  localparam int CONTROL_SIGNALS = 16;

  // Bit positions inside the control word that this stage reacts to
  localparam int MAI = 3;  // memory address register in (from bus)
  localparam int MI  = 4;  // RAM write from bus at current MAR
  localparam int MO  = 5;  // RAM read at current MAR onto bus

  // Memory stage states
  typedef enum logic [1:0] {
    MEM_ST_CLEAR = 2'd0,
    MEM_ST_RUN   = 2'd1,
    MEM_ST_LOAD  = 2'd2
  } mem_state_e;

  // Busy is asserted whenever the CPU must not advance
  function automatic logic state_is_busy(input mem_state_e st);
    return (st == MEM_ST_CLEAR) || (st == MEM_ST_LOAD);
  endfunction

endpackage : memory_module_pkg
`default_nettype wire

// File: rtl/ram_array_module.sv
`default_nettype none
// ============================================================================
//  Module      : ram_array_module
//  Description : 2^ADDR_WIDTH x DATA_WIDTH storage array with one
//                asynchronous read port and one synchronous write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_array_module #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Single write port, committed on the rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Zero-latency read; a same-cycle write is only visible after the edge
  assign rdata = mem[raddr];

endmodule : ram_array_module
`default_nettype wire

// File: rtl/memory_module.sv
`default_nettype none
// ============================================================================
//  Module      : memory_module
//  Description : Datapath memory stage: memory address register (MAR) and
//                RAM, with a program-load port and post-reset RAM clearing.
//                Drives RAM[mar] onto the shared bus when MO is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_module
  import memory_module_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CONTROL_SIGNALS-1:0] ctrl,
  input  logic [DATA_WIDTH-1:0]      bus_in,
  output logic [DATA_WIDTH-1:0]      mem_out,
  output logic                       mem_oe,
  input  logic                       prog_mode,
  input  logic                       prog_valid,
  input  logic [DATA_WIDTH-1:0]      prog_data,
  output logic                       prog_ready,
  output logic                       busy,
  output logic [ADDR_WIDTH-1:0]      load_addr
);

  // State entered on reset: clear pass first, or straight to normal running
  localparam mem_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? MEM_ST_CLEAR : MEM_ST_RUN;
  localparam logic       RST_BUSY  = (CLEAR_ON_RESET != 0);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  mem_state_e            state;
  logic [ADDR_WIDTH-1:0] mar;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  // RAM write port, selected by state
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Decoded control bits, only honoured while running
  logic run_mai;
  logic run_mi;
  logic run_mo;

  // Control bits other than MAI/MI/MO belong to other datapath blocks
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl;

  assign run_mai = (state == MEM_ST_RUN) && ctrl[MAI];
  assign run_mi  = (state == MEM_ST_RUN) && ctrl[MI];
  assign run_mo  = (state == MEM_ST_RUN) && ctrl[MO];

  // Bus drive: asynchronous read of the current (pre-edge) MAR
  assign mem_oe  = run_mo && !rst;
  assign mem_out = mem_oe ? ram_rdata : '0;

  // State machine, address registers and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RST_STATE;
      mar        <= '0;
      load_addr  <= '0;
      clr_cnt    <= '0;
      busy       <= RST_BUSY;
      prog_ready <= 1'b0;
    end else begin
      case (state)
        MEM_ST_CLEAR: begin
          // One word per cycle; prog_mode is not looked at until done
          clr_cnt <= clr_cnt + ADDR_ONE;
          if (clr_cnt == ADDR_LAST) begin
            state      <= MEM_ST_RUN;
            busy       <= state_is_busy(MEM_ST_RUN);
            prog_ready <= 1'b0;
          end
        end

        MEM_ST_RUN: begin
          // MAR load uses the bus value; a concurrent MI/MO used the old MAR
          if (run_mai) begin
            mar <= bus_in[ADDR_WIDTH-1:0];
          end
          if (prog_mode) begin
            state      <= MEM_ST_LOAD;
            load_addr  <= '0;
            busy       <= state_is_busy(MEM_ST_LOAD);
            prog_ready <= 1'b1;
          end
        end

        MEM_ST_LOAD: begin
          // Accepted byte advances the load pointer, wrapping at the top
          if (prog_valid) begin
            load_addr <= load_addr + ADDR_ONE;
          end
          // Leaving load mode still accepts a byte presented on the same edge
          if (!prog_mode) begin
            state      <= MEM_ST_RUN;
            busy       <= state_is_busy(MEM_ST_RUN);
            prog_ready <= 1'b0;
          end
        end

        default: begin
          state      <= RST_STATE;
          clr_cnt    <= '0;
          busy       <= RST_BUSY;
          prog_ready <= 1'b0;
        end
      endcase
    end
  end

  // Write-port mux: clear pattern, program bytes, or CPU bus writes
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = mar;
    ram_wdata = bus_in;
    if (!rst) begin
      case (state)
        MEM_ST_CLEAR: begin
          ram_we    = 1'b1;
          ram_waddr = clr_cnt;
          ram_wdata = '0;
        end
        MEM_ST_LOAD: begin
          ram_we    = prog_valid;
          ram_waddr = load_addr;
          ram_wdata = prog_data;
        end
        MEM_ST_RUN: begin
          ram_we    = run_mi;
          ram_waddr = mar;
          ram_wdata = bus_in;
        end
        default: begin
          ram_we = 1'b0;
        end
      endcase
    end
  end

  ram_array_module #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (mar),
    .rdata (ram_rdata)
  );

endmodule : memory_module
`default_nettype wire

// File: tb/tb_memory_module.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_module
//  Description : Directed self-checking bench for memory_module.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_module;
  import memory_module_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  localparam logic [CONTROL_SIGNALS-1:0] C_MAI = CONTROL_SIGNALS'(1) << MAI;
  localparam logic [CONTROL_SIGNALS-1:0] C_MI  = CONTROL_SIGNALS'(1) << MI;
  localparam logic [CONTROL_SIGNALS-1:0] C_MO  = CONTROL_SIGNALS'(1) << MO;

  logic                       clk;
  logic                       rst;
  logic [CONTROL_SIGNALS-1:0] ctrl;
  logic [DW-1:0]              bus_in;
  logic [DW-1:0]              mem_out;
  logic                       mem_oe;
  logic                       prog_mode;
  logic                       prog_valid;
  logic [DW-1:0]              prog_data;
  logic                       prog_ready;
  logic                       busy;
  logic [AW-1:0]              load_addr;

  int checks = 0;
  int errors = 0;

  memory_module #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (ctrl),
    .bus_in     (bus_in),
    .mem_out    (mem_out),
    .mem_oe     (mem_oe),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .busy       (busy),
    .load_addr  (load_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs changed afterwards and outputs sampled 1ns after
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy drops, bounded
  task automatic wait_not_busy(output int n);
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
  endtask

  // Read RAM[addr] in RUN: load MAR, then MO
  task automatic read_ram(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    ctrl   = C_MAI;
    bus_in = addr;
    tick();
    ctrl = C_MO;
    #1;
    data = mem_out;
    ctrl = '0;
  endtask

  logic [DW-1:0] rd;
  int            n;

  initial begin
    rst        = 1'b1;
    ctrl       = '0;
    bus_in     = '0;
    prog_mode  = 1'b0;
    prog_valid = 1'b0;
    prog_data  = '0;

    // ---- 1: reset and clear pass ----
    tick();
    check("rst_busy",       busy,       1);
    check("rst_prog_ready", prog_ready, 0);
    check("rst_load_addr",  load_addr,  0);
    ctrl = C_MO;
    #1;
    check("rst_mem_oe",  mem_oe,  0);
    check("rst_mem_out", mem_out, 0);
    ctrl = '0;
    rst  = 1'b0;
    wait_not_busy(n);
    check("clear_cycles", n, 256);
    read_ram(8'h00, rd); check("clear_ram00", rd, 8'h00);
    read_ram(8'hFF, rd); check("clear_ramFF", rd, 8'h00);
    read_ram(8'h7A, rd); check("clear_ram7A", rd, 8'h00);

    // ---- 2: short program load ----
    prog_mode = 1'b1;
    tick();
    check("load_busy",       busy,       1);
    check("load_prog_ready", prog_ready, 1);
    check("load_addr0",      load_addr,  0);
    prog_valid = 1'b1;
    prog_data = 8'h1E; tick();
    prog_data = 8'h2F; tick();
    prog_data = 8'hE0; tick();
    prog_valid = 1'b0;
    check("load_addr3", load_addr, 3);
    prog_mode = 1'b0;
    tick();
    check("load_exit_busy",  busy,       0);
    check("load_exit_ready", prog_ready, 0);
    read_ram(8'h00, rd); check("load_ram0", rd, 8'h1E);
    read_ram(8'h01, rd); check("load_ram1", rd, 8'h2F);
    read_ram(8'h02, rd); check("load_ram2", rd, 8'hE0);

    // ---- 3: wrapping load, last byte sent on the exit edge ----
    prog_mode = 1'b1;
    tick();
    prog_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      prog_data = 8'(i) ^ 8'h5A;
      tick();
    end
    prog_data = 8'hAA;
    prog_mode = 1'b0;
    tick();
    prog_valid = 1'b0;
    check("wrap_load_addr", load_addr, 1);
    check("wrap_busy",      busy,      0);
    read_ram(8'h00, rd); check("wrap_ram00", rd, 8'hAA);
    read_ram(8'h01, rd); check("wrap_ram01", rd, 8'h5B);
    read_ram(8'hFF, rd); check("wrap_ramFF", rd, 8'hA5);

    // ---- 4: MAI / MI / MO datapath ----
    ctrl = C_MAI; bus_in = 8'h0F; tick();
    ctrl = C_MO;  #1;
    check("mo_oe",    mem_oe,  1);
    check("mo_ram0F", mem_out, 8'h55);
    ctrl = C_MI; bus_in = 8'h20; tick();
    ctrl = C_MO; #1;
    check("mi_ram0F", mem_out, 8'h20);
    ctrl = C_MO | C_MAI; bus_in = 8'h20; #1;
    check("fetch_pre", mem_out, 8'h20);
    tick();
    ctrl = C_MO; #1;
    check("fetch_mar20", mem_out, 8'h7A);
    ctrl = C_MO | C_MI; bus_in = 8'h99; #1;
    check("momi_pre", mem_out, 8'h7A);
    tick();
    ctrl = C_MO; #1;
    check("momi_post", mem_out, 8'h99);
    ctrl = '0; #1;
    check("idle_oe",  mem_oe,  0);
    check("idle_out", mem_out, 0);

    // ---- 5: MI+MAI, then ctrl ignored while busy ----
    ctrl = C_MAI;        bus_in = 8'h30; tick();
    ctrl = C_MI | C_MAI; bus_in = 8'h55; tick();
    ctrl = C_MO; #1;
    check("mimai_mar55", mem_out, 8'h0F);
    read_ram(8'h30, rd); check("mimai_ram30", rd, 8'h55);
    ctrl = C_MAI; bus_in = 8'h30; tick();
    ctrl = '0;
    prog_mode = 1'b1;
    tick();
    ctrl = C_MI | C_MAI | C_MO; bus_in = 8'h77; #1;
    check("busy_oe",  mem_oe,  0);
    check("busy_out", mem_out, 0);
    tick();
    ctrl = '0;
    prog_mode = 1'b0;
    tick();
    ctrl = C_MO; #1;
    check("busy_ram30", mem_out, 8'h55);
    ctrl = '0;

    // ---- 6: reset during load ----
    prog_mode = 1'b1;
    tick();
    prog_valid = 1'b1;
    prog_data = 8'h11; tick();
    prog_data = 8'h22; tick();
    prog_data = 8'h33;
    rst = 1'b1;
    tick();
    check("rstload_ready", prog_ready, 0);
    check("rstload_busy",  busy,       1);
    rst        = 1'b0;
    prog_mode  = 1'b0;
    prog_valid = 1'b0;
    wait_not_busy(n);
    check("rstload_cycles", n, 256);
    read_ram(8'h00, rd); check("rstload_ram0", rd, 8'h00);
    read_ram(8'h01, rd); check("rstload_ram1", rd, 8'h00);
    read_ram(8'h02, rd); check("rstload_ram2", rd, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_memory_module
`default_nettype wire
